mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback formatter for the 32-bit MIPS core.
- Captures one instruction result per cycle from the memory stage.
- Performs load byte/halfword selection with sign or zero extension.
- Drives the register file write port (wen/wadd/wdata) one cycle later, plus forwarding copies of the same values for the decode/execute bypass.

Parameters:
DW, 32, data width of ALU result, load data and write data
AW, 5, register address width (32 architectural registers)
CNT_W, 32, width of the retired-instruction counter (optional feature only)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active low (0 = reset)
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can accept; equals ~stall
in_wen  input  1  instruction writes a register
in_waddr  input  AW  destination register number
in_alu  input  DW  ALU result / non-load write value
in_ltype  input  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6-7 treated as none
in_rdata  input  DW  raw aligned word from data memory
in_boff  input  2  byte offset (address[1:0]) of the load
stall  input  1  hold WB contents, suppress write
flush  input  1  discard WB contents
wen  output  1  register file write enable
wadd  output  AW  register file write address
wdata  output  DW  register file write data
adel  output  1  misaligned load detected for held instruction
fwd_valid  output  1  equals wen; bypass qualifier
fwd_addr  output  AW  equals wadd
fwd_data  output  DW  equals wdata

Behaviour:
- Reset (rst=0, asynchronous): internal valid=0, all held fields=0. Outputs: wen=0, wadd=0, wdata=0, adel=0, fwd_*=0, retire_cnt=0.
- Capture: at rising edge with rst=1, flush=0, stall=0, in_valid=1, store in_wen, in_waddr, in_alu, in_ltype, in_rdata and in_boff; set valid=1. If stall=0 and in_valid=0, set valid=0 (bubble).
- Priority per edge: flush > stall > capture. flush=1 clears valid regardless of stall or in_valid. stall=1 without flush holds all fields.
- Latency: instruction accepted at edge N has wen asserted in the cycle between edges N and N+1. The register file commits it at edge N+1.
- Formatting (combinational from held fields, little-endian lane = boff):
  - none: in_alu.
  - LB: sign-extended byte lane. LBU: zero-extended byte lane.
  - LH/LHU: halfword at boff[1] (lane 0 for boff=0, lane 1 for boff=2), sign- or zero-extended.
  - LW: in_rdata.
- Misalignment: LH/LHU with boff[0]=1, or LW with boff!=0, sets adel=valid. wen is suppressed for that instruction.
- wen = valid & held_wen & (wadd!=0) & ~stall & ~adel. Writes to $0 never assert wen. wadd/wdata reflect held fields even when wen=0.
- Reset mid-stall or mid-instruction: the held instruction is lost. Nothing is written after rst is released until a new capture occurs.
- Back-to-back: a new instruction each cycle with stall=0 yields one write per cycle, no gaps.

Optional Feature:
WB_RETIRE_CNT_EN: when defined, adds output retire_cnt (CNT_W bits).
- Reset value 0.
- Increments by 1 at each rising edge where valid=1, stall=0, flush=0 and adel=0, whether or not the instruction writes a register.
- Wraps from all-ones to 0.
When the macro is undefined, the port and counter do not exist and all other behaviour is identical.

Test Plan:
- Reset then release; present ALU op waddr=1, alu=0x4 -> next cycle wen=1, wadd=1, wdata=0x00000004; following cycle with in_valid=0 -> wen=0.
- LB, rdata=0x1280F034, boff=2 -> wdata=0xFFFFFF80. LBU same -> 0x00000080. LH boff=2 -> 0x00001280. LHU boff=0 -> 0x0000F034.
- Write to waddr=0 with alu=0x1 -> wen=0, fwd_valid=0. LW with boff=1 -> adel=1, wen=0, retire_cnt unchanged.
- Capture waddr=31, alu=0x7, then stall=1 for 3 cycles -> wen=0 and wadd=31 held; stall=0 -> wen=1 exactly one cycle, wdata=0x7.
- Held valid instruction with flush=1 and stall=1 at the same edge -> wen=0 next cycle. Assert rst=0 mid-stall -> all outputs 0 immediately, before the next clock edge.
- With WB_RETIRE_CNT_EN: 5 back-to-back valid instructions (one to $0, one stalled 2 cycles) -> retire_cnt=5. Preload counter near wrap (CNT_W=4, 16 retires) -> reads 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback formatter: holds one memory-stage result, formats load data and drives the register file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_wen,
  input  logic [AW-1:0] in_waddr,
  input  logic [DW-1:0] in_alu,
  input  logic [2:0]    in_ltype,
  input  logic [DW-1:0] in_rdata,
  input  logic [1:0]    in_boff,
  input  logic          stall,
  input  logic          flush,
  output logic          wen,
  output logic [AW-1:0] wadd,
  output logic [DW-1:0] wdata,
  output logic          adel,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  localparam logic [2:0] LT_LW  = 3'd5;

  logic          valid_r;
  logic          wen_r;
  logic [AW-1:0] waddr_r;
  logic [DW-1:0] alu_r;
  logic [2:0]    ltype_r;
  logic [DW-1:0] rdata_r;
  logic [1:0]    boff_r;

  logic          adel_s;
  logic          wen_s;
  logic [DW-1:0] wdata_s;

  function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] bo);
    logic bad;
    case (lt)
      LT_LH, LT_LHU: bad = bo[0];
      LT_LW:         bad = (bo != 2'b00);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Little-endian lane select; halfword lane comes from boff[1] only, so a misaligned
  // halfword still formats the enclosing lane even though it is never written.
  function automatic logic [DW-1:0] fmt_wdata(input logic [2:0] lt, input logic [1:0] bo,
                                              input logic [DW-1:0] alu, input logic [DW-1:0] rd);
    logic [7:0]    b;
    logic [15:0]   h;
    logic [DW-1:0] res;
    b = rd[{bo, 3'b000} +: 8];
    h = bo[1] ? rd[31:16] : rd[15:0];
    case (lt)
      LT_LB:   res = {{(DW-8){b[7]}}, b};
      LT_LBU:  res = {{(DW-8){1'b0}}, b};
      LT_LH:   res = {{(DW-16){h[15]}}, h};
      LT_LHU:  res = {{(DW-16){1'b0}}, h};
      LT_LW:   res = rd;
      default: res = alu;
    endcase
    return res;
  endfunction

  // Pipeline register: flush beats stall, stall beats capture; a bubble only drops valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      wen_r   <= 1'b0;
      waddr_r <= {AW{1'b0}};
      alu_r   <= {DW{1'b0}};
      ltype_r <= 3'd0;
      rdata_r <= {DW{1'b0}};
      boff_r  <= 2'd0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (stall) begin
      valid_r <= valid_r;
    end else if (in_valid) begin
      valid_r <= 1'b1;
      wen_r   <= in_wen;
      waddr_r <= in_waddr;
      alu_r   <= in_alu;
      ltype_r <= in_ltype;
      rdata_r <= in_rdata;
      boff_r  <= in_boff;
    end else begin
      valid_r <= 1'b0;
    end
  end

  // Writeback qualification and data formatting from the held instruction.
  always_comb begin
    adel_s  = 1'b0;
    wen_s   = 1'b0;
    wdata_s = fmt_wdata(ltype_r, boff_r, alu_r, rdata_r);
    if (valid_r) begin
      adel_s = is_misaligned(ltype_r, boff_r);
    end else begin
      adel_s = 1'b0;
    end
    if (valid_r && wen_r && (waddr_r != {AW{1'b0}}) && !stall && !adel_s) begin
      wen_s = 1'b1;
    end else begin
      wen_s = 1'b0;
    end
  end

  assign in_ready  = ~stall;
  assign wen       = wen_s;
  assign wadd      = waddr_r;
  assign wdata     = wdata_s;
  assign adel      = adel_s;
  assign fwd_valid = wen_s;
  assign fwd_addr  = waddr_r;
  assign fwd_data  = wdata_s;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_r;

  // Counts every instruction leaving the stage, including non-writing ones; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (valid_r && !stall && !flush && !adel_s) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign retire_cnt = retire_cnt_r;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, directed stall/flush/reset sequences, random run against a reference model.
module tb_mem_wb_stage;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_wen;
  logic [AW-1:0] in_waddr;
  logic [DW-1:0] in_alu;
  logic [2:0]    in_ltype;
  logic [DW-1:0] in_rdata;
  logic [1:0]    in_boff;
  logic          stall;
  logic          flush;
  logic          wen;
  logic [AW-1:0] wadd;
  logic [DW-1:0] wdata;
  logic          adel;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
`endif

  mem_wb_stage #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wen(in_wen), .in_waddr(in_waddr), .in_alu(in_alu), .in_ltype(in_ltype),
    .in_rdata(in_rdata), .in_boff(in_boff), .stall(stall), .flush(flush),
    .wen(wen), .wadd(wadd), .wdata(wdata), .adel(adel),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model: the instruction currently held in WB plus the retire count.
  logic        m_valid;
  logic        m_w;
  logic [4:0]  m_a;
  logic [31:0] m_alu;
  logic [2:0]  m_lt;
  logic [31:0] m_rd;
  logic [1:0]  m_bo;
  int          m_cnt;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] alu;
    logic [2:0]  lt;
    logic [31:0] rd;
    logic [1:0]  bo;
    logic        ew;
    logic [31:0] ed;
    logic        ea;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_w = 1'b0; m_a = 5'd0; m_alu = 32'd0;
    m_lt = 3'd0; m_rd = 32'd0; m_bo = 2'd0; m_cnt = 0;
  endtask

  function automatic logic [31:0] model_wdata();
    logic [31:0] b;
    logic [31:0] h;
    b = (m_rd >> (8 * m_bo)) & 32'h0000_00FF;
    h = (m_rd >> (16 * (m_bo / 2))) & 32'h0000_FFFF;
    case (m_lt)
      3'd1:    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
      3'd4:    return h;
      3'd5:    return m_rd;
      default: return m_alu;
    endcase
  endfunction

  function automatic logic model_adel();
    if (!m_valid) return 1'b0;
    if ((m_lt == 3'd3 || m_lt == 3'd4) && (m_bo % 2 == 1)) return 1'b1;
    if (m_lt == 3'd5 && m_bo != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_wen();
    return m_valid && m_w && (m_a != 5'd0) && !stall && !model_adel();
  endfunction

  task automatic check_all();
    chk("wen", wen, model_wen());
    chk("fwd_valid", fwd_valid, model_wen());
    chk("adel", adel, model_adel());
    chk("in_ready", in_ready, !stall);
    if (m_valid) begin
      chk("wadd", wadd, m_a);
      chk("wdata", wdata, model_wdata());
      chk("fwd_addr", fwd_addr, m_a);
      chk("fwd_data", fwd_data, model_wdata());
    end
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, m_cnt);
`endif
  endtask

  task automatic model_edge();
    if (m_valid && !stall && !flush && !model_adel()) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (flush) m_valid = 1'b0;
    else if (stall) m_valid = m_valid;
    else if (in_valid) begin
      m_valid = 1'b1; m_w = in_wen; m_a = in_waddr; m_alu = in_alu;
      m_lt = in_ltype; m_rd = in_rdata; m_bo = in_boff;
    end else m_valid = 1'b0;
  endtask

  task automatic apply(input logic v, input logic w, input logic [4:0] a, input logic [31:0] alu,
                       input logic [2:0] lt, input logic [31:0] rd, input logic [1:0] bo,
                       input logic st, input logic fl);
    in_valid = v; in_wen = w; in_waddr = a; in_alu = alu; in_ltype = lt;
    in_rdata = rd; in_boff = bo; stall = st; flush = fl;
    #1;
    check_all();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic w, input logic [4:0] a, input logic [31:0] alu,
                     input logic [2:0] lt, input logic [31:0] rd, input logic [1:0] bo,
                     input logic st, input logic fl);
    apply(v, w, a, alu, lt, rd, bo, st, fl);
    tick();
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_reset();
    rst = 1'b0;
    in_valid = 1'b0; in_wen = 1'b0; in_waddr = 5'd0; in_alu = 32'd0;
    in_ltype = 3'd0; in_rdata = 32'd0; in_boff = 2'd0; stall = 1'b0; flush = 1'b0;

    tbl[0]  = '{1'b1, 5'd1,  32'h0000_0004, 3'd0, 32'h0000_0000, 2'd0, 1'b1, 32'h0000_0004, 1'b0};
    tbl[1]  = '{1'b1, 5'd2,  32'h0000_0000, 3'd1, 32'h1280_F034, 2'd2, 1'b1, 32'hFFFF_FF80, 1'b0};
    tbl[2]  = '{1'b1, 5'd2,  32'h0000_0000, 3'd2, 32'h1280_F034, 2'd2, 1'b1, 32'h0000_0080, 1'b0};
    tbl[3]  = '{1'b1, 5'd3,  32'h0000_0000, 3'd3, 32'h1280_F034, 2'd2, 1'b1, 32'h0000_1280, 1'b0};
    tbl[4]  = '{1'b1, 5'd3,  32'h0000_0000, 3'd4, 32'h1280_F034, 2'd0, 1'b1, 32'h0000_F034, 1'b0};
    tbl[5]  = '{1'b1, 5'd0,  32'h0000_0001, 3'd0, 32'h0000_0000, 2'd0, 1'b0, 32'h0000_0001, 1'b0};
    tbl[6]  = '{1'b1, 5'd4,  32'h0000_0000, 3'd5, 32'h1280_F034, 2'd1, 1'b0, 32'h1280_F034, 1'b1};
    tbl[7]  = '{1'b1, 5'd4,  32'h0000_0000, 3'd5, 32'hDEAD_BEEF, 2'd0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{1'b1, 5'd5,  32'h0000_0000, 3'd3, 32'h1280_F034, 2'd1, 1'b0, 32'hFFFF_F034, 1'b1};
    tbl[9]  = '{1'b1, 5'd6,  32'h0000_0000, 3'd1, 32'h1280_F034, 2'd3, 1'b1, 32'h0000_0012, 1'b0};
    tbl[10] = '{1'b1, 5'd6,  32'h0000_0000, 3'd1, 32'h1280_F034, 2'd1, 1'b1, 32'hFFFF_FFF0, 1'b0};
    tbl[11] = '{1'b1, 5'd7,  32'h0000_55AA, 3'd7, 32'h1280_F034, 2'd1, 1'b1, 32'h0000_55AA, 1'b0};
    tbl[12] = '{1'b0, 5'd8,  32'h0000_0009, 3'd0, 32'h0000_0000, 2'd0, 1'b0, 32'h0000_0009, 1'b0};

    #2;
    chk("rst_wen", wen, 1'b0);
    chk("rst_wadd", wadd, 5'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_adel", adel, 1'b0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    chk("rst_fwd_addr", fwd_addr, 5'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire_cnt", retire_cnt, 4'd0);
`endif
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, tbl[i].w, tbl[i].a, tbl[i].alu, tbl[i].lt, tbl[i].rd, tbl[i].bo, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_wen", i), wen, tbl[i].ew);
      chk($sformatf("tbl%0d_wdata", i), wdata, tbl[i].ed);
      chk($sformatf("tbl%0d_adel", i), adel, tbl[i].ea);
      chk($sformatf("tbl%0d_wadd", i), wadd, tbl[i].a);
    end
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    chk("bubble_wen", wen, 1'b0);

    // Stall holds the instruction and suppresses the write until released.
    cyc(1'b1, 1'b1, 5'd31, 32'h0000_0007, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b1, 5'd9, 32'h0000_0BAD, 3'd0, 32'd0, 2'd0, 1'b1, 1'b0);
      chk("stall_wen", wen, 1'b0);
      chk("stall_wadd", wadd, 5'd31);
      tick();
    end
    apply(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    chk("stall_rel_wen", wen, 1'b1);
    chk("stall_rel_wdata", wdata, 32'h0000_0007);
    tick();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    chk("stall_once_wen", wen, 1'b0);
    tick();

    // Flush wins over a simultaneous stall.
    cyc(1'b1, 1'b1, 5'd5, 32'h0000_0009, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'd12, 32'h0000_0033, 3'd0, 32'd0, 2'd0, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    chk("flush_wen", wen, 1'b0);
    chk("flush_fwd_valid", fwd_valid, 1'b0);
    tick();

    // Asynchronous reset while stalled: outputs clear before any clock edge.
    cyc(1'b1, 1'b1, 5'd6, 32'h0000_00AB, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 5'd7, 32'h0000_0001, 3'd0, 32'd0, 2'd0, 1'b1, 1'b0);
    chk("pre_rst_wadd", wadd, 5'd6);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_wen", wen, 1'b0);
    chk("async_rst_wadd", wadd, 5'd0);
    chk("async_rst_wdata", wdata, 32'd0);
    chk("async_rst_fwd_data", fwd_data, 32'd0);
    model_reset();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    chk("post_rst_wen", wen, 1'b0);
    tick();

    for (int r = 0; r < 400; r++) begin
      cyc(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0) % 8),
          $urandom, 3'($urandom_range(7, 0)), $urandom, 2'($urandom_range(3, 0)),
          ($urandom_range(4, 0) == 0), ($urandom_range(19, 0) == 0));
    end

`ifdef WB_RETIRE_CNT_EN
    do_reset();
    cyc(1'b1, 1'b1, 5'd1, 32'd1, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'd0, 32'd2, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'd2, 32'd3, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'd3, 32'd4, 3'd0, 32'd0, 2'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 5'd3, 32'd4, 3'd0, 32'd0, 2'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 5'd3, 32'd4, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 5'd4, 32'd5, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    chk("retire_five", retire_cnt, 4'd5);
    cyc(1'b1, 1'b1, 5'd4, 32'd0, 3'd5, 32'd0, 2'd1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    chk("retire_adel_skip", retire_cnt, 4'd5);
    do_reset();
    for (int n = 0; n < 16; n++) begin
      cyc(1'b1, 1'b1, 5'd8, 32'(n), 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
      if (n == 15) chk("retire_all_ones", retire_cnt, 4'd15);
    end
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    chk("retire_wrap", retire_cnt, 4'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
